change_capture_fifo: RTL and testbench

Downstream observer stage for the `for_loop_test_3` datapath. It samples the stage's `WIDTH`-bit output every clock and detects value changes. Each change is pushed, with a free-running timestamp, into a small FIFO. A consumer drains the FIFO over a valid/ready interface. The block replaces `$monitor`-style observation with a synthesizable capture path usable in gate-level runs.

---
 rtl/change_capture_pkg.sv | 25 ++
 rtl/cc_sync_fifo.sv | 70 +++++++
 rtl/change_capture_fifo.sv | 84 ++++++++
 tb/tb_change_capture_fifo.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_capture_pkg.sv
// Shared types and helpers for the change capture FIFO.
// Holds the capture entry layout and the pointer full test.
package change_capture_pkg;

   localparam int CC_WIDTH    = 4;
   localparam int CC_TS_WIDTH = 16;

   typedef struct packed {
      logic [CC_WIDTH-1:0]    data;
      logic [CC_TS_WIDTH-1:0] ts;
   } capture_entry_t;

   // Pointers carry one wrap bit above aw address bits.
   // Full means only the wrap bit differs.
   function automatic logic ptr_full(
      input logic [31:0] wr,
      input logic [31:0] rd,
      input int          aw
   );
      logic [31:0] diff;
      diff = wr ^ rd;
      return diff == (32'd1 << aw);
   endfunction

endpackage

// File: rtl/cc_sync_fifo.sv
// Generic single-clock FIFO with clear, registered count, reset storage.
// Ports: clk, rst_n, clear, push, pop, wr_data, rd_data, count, full, empty.
module cc_sync_fifo
   import change_capture_pkg::*;
#(
   parameter int DATA_W = 20,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push_ok;
   logic              pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = ptr_full(32'(wr_ptr), 32'(rd_ptr), AW);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot a full push needs.
   assign push_ok = push && (!full || pop_ok);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok && !clear) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
         if (push_ok && !pop_ok) begin
            count <= count + (AW+1)'(1);
         end else if (pop_ok && !push_ok) begin
            count <= count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/change_capture_fifo.sv
// Samples in_data each cycle and queues {value, timestamp} on every change.
// Ports: clk, rst_n, in_data, capture_en, clear, rd_valid/rd_ready/rd_data/rd_ts, count, overflow.
module change_capture_fifo
   import change_capture_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 8,
   parameter int TS_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       in_data,
   input  logic                   capture_en,
   input  logic                   clear,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [WIDTH-1:0]       rd_data,
   output logic [TS_WIDTH-1:0]    rd_ts,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int EW = WIDTH + TS_WIDTH;

   logic [TS_WIDTH-1:0] ts_q;
   logic [WIDTH-1:0]    prev_q;
   logic                primed_q;
   logic                capture;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [EW-1:0]       wr_entry;
   logic [EW-1:0]       rd_entry;

   // First enabled cycle captures a baseline, later only changes.
   assign capture  = capture_en && (!primed_q || (in_data != prev_q));
   assign push     = capture && !clear;
   assign pop      = rd_valid && rd_ready && !clear;
   assign wr_entry = {in_data, ts_q};
   assign rd_valid = !empty;
   assign rd_data  = rd_entry[TS_WIDTH +: WIDTH];
   assign rd_ts    = rd_entry[TS_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q     <= '0;
         prev_q   <= '0;
         primed_q <= 1'b0;
      end else begin
         ts_q     <= ts_q + TS_WIDTH'(1);
         prev_q   <= in_data;
         primed_q <= capture_en;
      end
   end

   // Sticky until clear; a full push rescued by a pop is not a drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (clear) begin
         overflow <= 1'b0;
      end else if (push && full && !pop) begin
         overflow <= 1'b1;
      end
   end

   cc_sync_fifo #(
      .DATA_W (EW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_entry),
      .rd_data (rd_entry),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

endmodule

// File: tb/tb_change_capture_fifo.sv
// Directed bench for change_capture_fifo.
// Drives after each rising edge, checks 1 time unit later.
module tb_change_capture_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  in_data;
   logic        capture_en;
   logic        clear;
   logic        rd_valid;
   logic        rd_ready;
   logic [3:0]  rd_data;
   logic [15:0] rd_ts;
   logic [3:0]  count;
   logic        overflow;

   int vectors = 0;
   int errors  = 0;

   logic [15:0] ts_m = 16'd0;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ts_m <= 16'd0;
      else        ts_m <= ts_m + 16'd1;
   end

   change_capture_fifo #(
      .WIDTH    (4),
      .DEPTH    (8),
      .TS_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .capture_en (capture_en),
      .clear      (clear),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_data    (rd_data),
      .rd_ts      (rd_ts),
      .count      (count),
      .overflow   (overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_data = 4'd0; capture_en = 1'b0;
      clear = 1'b0; rd_ready = 1'b0;
      repeat (3) step();
      vectors++;
      if (rd_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid);
      end
      vectors++;
      if (count !== 4'd0) begin
         errors++; $display("FAIL reset_count got %0d want 0", count);
      end
      vectors++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL reset_overflow got %b want 0", overflow);
      end
      vectors++;
      if (rd_data !== 4'd0 || rd_ts !== 16'd0) begin
         errors++;
         $display("FAIL reset_head got %h/%0d want 0/0", rd_data, rd_ts);
      end
      rst_n = 1'b1; capture_en = 1'b1; in_data = 4'b0000;
      step();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 4'd0 || rd_ts !== 16'd0 ||
          count !== 4'd1) begin
         errors++;
         $display("FAIL baseline got v=%b d=%h ts=%0d c=%0d want 1/0/0/1",
                  rd_valid, rd_data, rd_ts, count);
      end
   endtask

   task automatic test_sweep();
      logic [15:0] exp_ts;
      rd_ready = 1'b1; in_data = 4'd0;
      step();
      vectors++;
      if (rd_valid !== 1'b0) begin
         errors++; $display("FAIL sweep_v0 got rd_valid %b want 0", rd_valid);
      end
      for (int v = 1; v < 16; v++) begin
         in_data = 4'(v);
         exp_ts  = ts_m;
         step();
         vectors++;
         if (rd_valid !== 1'b1 || rd_data !== 4'(v) || rd_ts !== exp_ts ||
             count !== 4'd1) begin
            errors++;
            $display("FAIL sweep_%0d got v=%b d=%h ts=%0d c=%0d want 1/%h/%0d/1",
                     v, rd_valid, rd_data, rd_ts, count, v, exp_ts);
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL sweep_overflow got %b want 0", overflow);
      end
      step();
      rd_ready = 1'b0;
   endtask

   task automatic test_overflow();
      logic [15:0] ots [8];
      for (int i = 0; i < 10; i++) begin
         in_data = 4'(i);
         if (i < 8) ots[i] = ts_m;
         step();
      end
      vectors++;
      if (count !== 4'd8 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_fill got c=%0d o=%b want 8/1", count, overflow);
      end
      rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (rd_valid !== 1'b1 || rd_data !== 4'(i) || rd_ts !== ots[i]) begin
            errors++;
            $display("FAIL ovf_drain_%0d got v=%b d=%h ts=%0d want 1/%h/%0d",
                     i, rd_valid, rd_data, rd_ts, i, ots[i]);
         end
         step();
      end
      rd_ready = 1'b0;
      vectors++;
      if (rd_valid !== 1'b0 || count !== 4'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_empty got v=%b c=%0d o=%b want 0/0/1",
                  rd_valid, count, overflow);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      vectors++;
      if (count !== 4'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got c=%0d o=%b want 0/0", count, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      logic [15:0] fts [8];
      logic [15:0] tail_ts;
      for (int i = 0; i < 8; i++) begin
         in_data = 4'(i + 1);
         fts[i]  = ts_m;
         step();
      end
      vectors++;
      if (count !== 4'd8 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_fill got c=%0d o=%b want 8/0", count, overflow);
      end
      in_data = 4'd12; tail_ts = ts_m; rd_ready = 1'b1;
      step();
      vectors++;
      if (count !== 4'd8 || overflow !== 1'b0 || rd_data !== 4'd2) begin
         errors++;
         $display("FAIL full_pushpop got c=%0d o=%b d=%h want 8/0/2",
                  count, overflow, rd_data);
      end
      for (int i = 1; i < 8; i++) begin
         vectors++;
         if (rd_data !== 4'(i + 1) || rd_ts !== fts[i]) begin
            errors++;
            $display("FAIL full_drain_%0d got d=%h ts=%0d want %h/%0d",
                     i, rd_data, rd_ts, i + 1, fts[i]);
         end
         step();
      end
      vectors++;
      if (rd_data !== 4'd12 || rd_ts !== tail_ts || count !== 4'd1) begin
         errors++;
         $display("FAIL full_tail got d=%h ts=%0d c=%0d want c/%0d/1",
                  rd_data, rd_ts, count, tail_ts);
      end
      step();
      rd_ready = 1'b0;
      vectors++;
      if (rd_valid !== 1'b0) begin
         errors++; $display("FAIL full_empty got rd_valid %b want 0", rd_valid);
      end
   endtask

   task automatic test_enable_gating();
      logic [15:0] base_ts;
      capture_en = 1'b0;
      for (int i = 3; i < 8; i++) begin
         in_data = 4'(i);
         step();
      end
      in_data = 4'b1010;
      step();
      vectors++;
      if (count !== 4'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL gate_off got c=%0d v=%b want 0/0", count, rd_valid);
      end
      capture_en = 1'b1; base_ts = ts_m;
      step();
      step();
      vectors++;
      if (count !== 4'd1 || rd_data !== 4'b1010 || rd_ts !== base_ts) begin
         errors++;
         $display("FAIL gate_baseline got c=%0d d=%h ts=%0d want 1/a/%0d",
                  count, rd_data, rd_ts, base_ts);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i < 5; i++) begin
         in_data = 4'(i);
         step();
      end
      vectors++;
      if (count !== 4'd5) begin
         errors++; $display("FAIL arst_pre got c=%0d want 5", count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (rd_valid !== 1'b0 || count !== 4'd0 || rd_data !== 4'd0 ||
          overflow !== 1'b0) begin
         errors++;
         $display("FAIL arst_now got v=%b c=%0d d=%h o=%b want 0/0/0/0",
                  rd_valid, count, rd_data, overflow);
      end
      step();
      rst_n = 1'b1;
      step();
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== 4'd4 || rd_ts !== 16'd0 ||
          count !== 4'd1) begin
         errors++;
         $display("FAIL arst_restart got v=%b d=%h ts=%0d c=%0d want 1/4/0/1",
                  rd_valid, rd_data, rd_ts, count);
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_overflow();
      test_full_push_pop();
      test_enable_gating();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
